// File: rtl/write_back_pkg.sv
// Shared definitions for the Beta write-back stage: instruction encodings,
// register indices, the load-timeout fill value and the stage state encoding.
package write_back_pkg;

    // ADD(R31, R31, R31): the bubble injected by earlier stages
    localparam logic [31:0] INST_NOP = 32'h83FF_F800;

    // BNE(R31, 0, XP): the instruction substituted on an exception
    localparam logic [31:0] INST_XBNE = 32'h77DF_0000;

    // Value written to the register file when a load is abandoned
    localparam logic [31:0] LD_TIMEOUT_VALUE = 32'hDEAD_BEEF;

    localparam logic [4:0] REG_XP  = 5'd30;
    localparam logic [4:0] REG_R31 = 5'd31;

    typedef enum logic {
        WB_RUN     = 1'b0,
        WB_WAIT_LD = 1'b1
    } wb_state_e;

    // Destination register field of a Beta instruction
    function automatic logic [4:0] rc_field(input logic [31:0] inst);
        return inst[25:21];
    endfunction

endpackage

// File: rtl/write_back_counters.sv
// Free-running performance counters of the write-back stage. Both counters
// wrap silently at 2^CNT_W.
module wb_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_instret,
    input  logic             inc_ld_wait,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] ld_wait_cycles
);

    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] ld_wait_q, ld_wait_d;

    // Next-count computation; a plain add gives the wrap-around for free
    always_comb begin
        instret_d = instret_q;
        ld_wait_d = ld_wait_q;
        if (inc_instret) begin
            instret_d = instret_q + 1'b1;
        end
        if (inc_ld_wait) begin
            ld_wait_d = ld_wait_q + 1'b1;
        end
    end

    // Counter registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
            ld_wait_q <= '0;
        end else begin
            instret_q <= instret_d;
            ld_wait_q <= ld_wait_d;
        end
    end

    assign instret        = instret_q;
    assign ld_wait_cycles = ld_wait_q;

endmodule

// File: rtl/write_back.sv
// Beta pipeline write-back stage: registers the memory-access results, waits
// for load data, selects the register-file write value and counts retirements.
module write_back
    import write_back_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int LD_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc,
    input  logic [31:0]      ir,
    input  logic [31:0]      y,
    input  logic             op_ld_or_ldr,
    input  logic             op_st,
    input  logic             rf_w_mux_jump,
    input  logic [31:0]      mem_r_data,
    input  logic             mem_r_valid,
    output logic             wb_stall,
    output logic             rf_we,
    output logic [4:0]       rf_w_addr,
    output logic [31:0]      rf_w_data,
    output logic             byp_valid,
    output logic             byp_pending,
    output logic             ld_err,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] ld_wait_cycles
);

    localparam int WAIT_W = $clog2(LD_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(LD_TIMEOUT);

    // Stage input registers
    logic [31:0] pc_wb_q, pc_wb_d;
    logic [31:0] ir_wb_q, ir_wb_d;
    logic [31:0] y_wb_q, y_wb_d;
    logic        ld_wb_q, ld_wb_d;
    logic        st_wb_q, st_wb_d;
    logic        jump_wb_q, jump_wb_d;

    // Control state
    wb_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              ld_err_q, ld_err_d;

    // Decoded / derived signals
    logic [4:0]        rc;
    logic              writes_rf;
    logic              retire;
    logic              stall;
    logic              wait_inc;
    logic              timeout_hit;
    logic [WAIT_W-1:0] wait_next;
    logic              we_c;
    logic [31:0]       wr_sel;

    // Input register next-state: capture upstream values unless stalled
    always_comb begin
        pc_wb_d   = pc_wb_q;
        ir_wb_d   = ir_wb_q;
        y_wb_d    = y_wb_q;
        ld_wb_d   = ld_wb_q;
        st_wb_d   = st_wb_q;
        jump_wb_d = jump_wb_q;
        if (!stall) begin
            pc_wb_d   = pc;
            ir_wb_d   = ir;
            y_wb_d    = y;
            ld_wb_d   = op_ld_or_ldr;
            st_wb_d   = op_st;
            jump_wb_d = rf_w_mux_jump;
        end
    end

    // Input registers; reset leaves a NOP in the stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_wb_q   <= '0;
            ir_wb_q   <= INST_NOP;
            y_wb_q    <= '0;
            ld_wb_q   <= 1'b0;
            st_wb_q   <= 1'b0;
            jump_wb_q <= 1'b0;
        end else begin
            pc_wb_q   <= pc_wb_d;
            ir_wb_q   <= ir_wb_d;
            y_wb_q    <= y_wb_d;
            ld_wb_q   <= ld_wb_d;
            st_wb_q   <= st_wb_d;
            jump_wb_q <= jump_wb_d;
        end
    end

    // Load-wait control: decide stall/retire and the next wait state
    always_comb begin
        rc          = rc_field(ir_wb_q);
        writes_rf   = !st_wb_q && (rc != REG_R31);
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ld_err_d    = ld_err_q;
        retire      = 1'b0;
        stall       = 1'b0;
        wait_inc    = 1'b0;
        timeout_hit = 1'b0;
        wait_next   = wait_cnt_q + 1'b1;
        case (state_q)
            WB_RUN: begin
                // A jump writes pc, so its load flag never needs memory data
                if (ld_wb_q && !jump_wb_q && !mem_r_valid) begin
                    stall      = 1'b1;
                    state_d    = WB_WAIT_LD;
                    wait_cnt_d = '0;
                end else begin
                    retire = 1'b1;
                end
            end
            WB_WAIT_LD: begin
                wait_inc   = 1'b1;
                wait_cnt_d = wait_next;
                if (mem_r_valid) begin
                    retire  = 1'b1;
                    state_d = WB_RUN;
                end else if (wait_next == TIMEOUT_CNT) begin
                    retire      = 1'b1;
                    timeout_hit = 1'b1;
                    ld_err_d    = 1'b1;
                    state_d     = WB_RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = WB_RUN;
            end
        endcase
    end

    // State, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WB_RUN;
            wait_cnt_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ld_err_q   <= ld_err_d;
        end
    end

    // Write-value select: jump beats load beats ALU result
    always_comb begin
        we_c = retire && writes_rf;
        if (jump_wb_q) begin
            wr_sel = pc_wb_q;
        end else if (ld_wb_q) begin
            wr_sel = timeout_hit ? LD_TIMEOUT_VALUE : mem_r_data;
        end else begin
            wr_sel = y_wb_q;
        end
    end

    wb_counters #(
        .CNT_W(CNT_W)
    ) u_counters (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_instret    (retire && (ir_wb_q != INST_NOP)),
        .inc_ld_wait    (wait_inc),
        .instret        (instret),
        .ld_wait_cycles (ld_wait_cycles)
    );

    assign wb_stall    = stall;
    assign rf_we       = we_c;
    assign rf_w_addr   = we_c ? rc : 5'd0;
    assign rf_w_data   = we_c ? wr_sel : 32'd0;
    assign byp_valid   = we_c;
    assign byp_pending = stall && writes_rf;
    assign ld_err      = ld_err_q;

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final (WB) stage of the Beta pipeline. Directly downstream of the memory-access stage and consumes its pc/ir/y outputs and its registered control bits.
- Registers those values, then waits for the data-memory read response on loads.
- Selects the register-file write value from pc (jumps/branches), load data or ALU result, and drives the register-file write port and the WB bypass path.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction and load-wait counters.
- LD_TIMEOUT, 255, maximum cycles spent in WAIT_LD before the load is abandoned with an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- pc  in  32  pc from memory-access stage (already PC+4).
- ir  in  32  instruction from memory-access stage (exception/NOP substitution already applied).
- y  in  32  ALU result / memory address.
- op_ld_or_ldr  in  1  instruction is LD/LDR.
- op_st  in  1  instruction is ST.
- rf_w_mux_jump  in  1  write pc instead of data (BR/JMP/exception).
- mem_r_data  in  32  data-memory read data.
- mem_r_valid  in  1  mem_r_data valid this cycle.
- wb_stall  out  1  hold all upstream stages this cycle.
- rf_we  out  1  register-file write enable.
- rf_w_addr  out  5  destination register (ir[25:21]).
- rf_w_data  out  32  register-file write data.
- byp_valid  out  1  rf_w_data valid for decode bypass.
- byp_pending  out  1  WB holds a load whose data is not yet available (decode must interlock on rc).
- ld_err  out  1  sticky load timeout flag.
- instret  out  CNT_W  retired-instruction count.
- ld_wait_cycles  out  CNT_W  total cycles spent in WAIT_LD.

Behaviour:
- Input register:
  - On posedge clk with rst_n=1 and wb_stall=0, latch pc, ir, y and the three control bits into wb_* registers.
  - While wb_stall=1, the registers hold.
  - Reset loads ir_wb=INST_NOP, all control bits 0, pc/y 0.
- Decoded fields: rc = ir_wb[25:21]; writes_rf = !op_st_wb && rc != 31.
- FSM states RUN and WAIT_LD; reset state is RUN.
- RUN:
  - If op_ld_or_ldr_wb=1 and mem_r_valid=0, go to WAIT_LD and assert wb_stall combinationally this cycle.
  - Otherwise retire this cycle.
- WAIT_LD:
  - wb_stall=1 and byp_pending=1 (when writes_rf).
  - Each cycle, increment the wait counter and ld_wait_cycles.
  - mem_r_valid=1: retire with mem_r_data, deassert wb_stall in the same cycle, go to RUN.
  - Wait counter reaches LD_TIMEOUT with no valid: retire with 32'hDEADBEEF, set ld_err, go to RUN.
  - mem_r_valid arriving in the timeout cycle wins; ld_err is not set.
- Retire cycle:
  - rf_we = writes_rf.
  - rf_w_data = pc_wb if rf_w_mux_jump_wb; mem_r_data (or timeout value) if op_ld_or_ldr_wb; else y_wb. Jump has priority over load.
  - byp_valid = rf_we.
  - instret increments unless ir_wb == INST_NOP; ST and R31-destination ops do count.
- Non-retire cycles: rf_we=0, byp_valid=0.
- Combinational output latency: rf_w_* are combinational from the wb_* registers, so an instruction is written one cycle after it leaves memory-access (zero extra cycles for ALU ops).
- Counters wrap at 2^CNT_W without a flag. ld_err clears only on reset.
- Reset mid-WAIT_LD: FSM returns to RUN, the pending load is discarded with no rf write, and all outputs go to 0.
- Reset values: wb_stall 0, rf_we 0, rf_w_addr 0, rf_w_data 0 (driven from reset registers), byp_valid 0, byp_pending 0, ld_err 0, instret 0, ld_wait_cycles 0.

Decomposition:
- Shared package (defines): INST_NOP, the exception BNE encoding, LD_TIMEOUT_VALUE 32'hDEADBEEF, the XP/R31 register indices, and the state encoding WB_RUN/WB_WAIT_LD.
- One natural sub-module: wb_counters, holding the instret and ld_wait_cycles counters with wrap behaviour. Everything else stays in write_back.

Test Plan:
- ADD retiring with y=32'h1234, rc=3 -> next cycle rf_we=1, rf_w_addr=3, rf_w_data=32'h1234, byp_valid=1, instret=1.
- LD, rc=5, mem_r_valid low for 3 cycles then data 32'hCAFEF00D -> wb_stall high for exactly 3 cycles, byp_pending high, then rf_w_data=32'hCAFEF00D, ld_wait_cycles=3.
- BR, rc=28, pc=32'h40 with rf_w_mux_jump=1 and op_ld_or_ldr=1 both set -> rf_w_data=32'h40 (jump priority), no stall.
- ST, and separately ADD with rc=31 -> rf_we=0 for both; instret increments by 2. INST_NOP -> instret unchanged.
- LD with mem_r_valid never asserted (LD_TIMEOUT=4) -> stall 4 cycles, rf_w_data=32'hDEADBEEF, ld_err=1 sticky through later traffic.
- rst_n low during cycle 2 of WAIT_LD -> next cycle state RUN, wb_stall=0, rf_we=0, counters 0, ld_err 0.
